wb_stage: RTL

//  MEM/WB pipeline register plus writeback mux: the producer side of the register-file write port.
//  - Captures MEM-stage results and selects ALU result, extended load data or PC+4.
//  - Drives writeReg/writeData/regWrite into the register file.
//  - Mirrors the same values on a forwarding bus for EX-stage bypass.
//  - Sits between the data-memory stage and the register file in the 5-stage RV32I core.

---
 rtl/wb_stage_pkg.sv | 24 ++
 rtl/wb_stage_load_extend.sv | 27 ++
 rtl/wb_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared writeback constants and the MEM/WB register layout.
//   WB_SEL_*  writeback source select codes (2-bit)
//   F3_*      load funct3 encodings as in the RV32I ISA
//   memwb_t   fields held in the MEM/WB pipeline register
package wb_stage_pkg;
   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic        reg_write;
      logic [1:0]  wb_sel;
      logic [2:0]  funct3;
      logic [31:0] alu_result;
      logic [31:0] mem_rdata;
      logic [31:0] pc_plus4;
   } memwb_t;
endpackage

// File: rtl/wb_stage_load_extend.sv
// wb_stage_load_extend: selects the load lane and sign/zero-extends it.
//   funct3_i  load width/sign
//   offset_i  byte offset within the word (alu_result[1:0])
//   rdata_i   raw aligned memory word
//   data_o    extended load value; LW and unused encodings pass the word through
module wb_stage_load_extend
   import wb_stage_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);
   logic [31:0] shifted;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      shifted = rdata_i >> {offset_i, 3'b000};
      b = shifted[7:0];
      h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      data_o = funct3_i == F3_LB  ? {{24{b[7]}}, b} :
               funct3_i == F3_LBU ? {24'h0, b} :
               funct3_i == F3_LH  ? {{16{h[15]}}, h} :
               funct3_i == F3_LHU ? {16'h0, h} :
               rdata_i;
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus writeback mux driving the regfile write port.
//   Inputs : clk, rst (sync, active-high), stall, flush, in_valid, in_rd, in_reg_write,
//            in_wb_sel, in_funct3, in_alu_result, in_mem_rdata, in_pc_plus4
//   Outputs: writeReg, writeData, regWrite, wb_valid, fwd_en/fwd_rd/fwd_data (copies
//            of the write port), instret (only when WB_INSTRET_EN is defined)
//   Macro  : WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_PC4 = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [4:0]      in_rd,
   input  logic            in_reg_write,
   input  logic [1:0]      in_wb_sel,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_mem_rdata,
   input  logic [XLEN-1:0] in_pc_plus4,
   output logic [4:0]      writeReg,
   output logic [XLEN-1:0] writeData,
   output logic            regWrite,
   output logic            wb_valid,
   output logic            fwd_en,
   output logic [4:0]      fwd_rd,
   output logic [XLEN-1:0] fwd_data
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]     instret
`endif
);
   memwb_t      wb_q, wb_d;
   logic [31:0] ld_data;
   always_comb
      wb_d = flush ? memwb_t'('0) :
             stall ? wb_q :
             memwb_t'{valid: in_valid, rd: in_rd, reg_write: in_reg_write, wb_sel: in_wb_sel,
                      funct3: in_funct3, alu_result: in_alu_result, mem_rdata: in_mem_rdata,
                      pc_plus4: in_pc_plus4};
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q          <= '0;
         wb_q.pc_plus4 <= RESET_PC4;
      end else begin
         wb_q <= wb_d;
      end
   end
   wb_stage_load_extend u_ext (
      .funct3_i(wb_q.funct3),
      .offset_i(wb_q.alu_result[1:0]),
      .rdata_i (wb_q.mem_rdata),
      .data_o  (ld_data)
   );
   // x0 writes are dropped here so the forwarding bus never advertises x0.
   assign regWrite  = wb_q.valid & wb_q.reg_write & (wb_q.rd != 5'd0);
   assign writeReg  = wb_q.rd;
   assign writeData = wb_q.wb_sel == WB_SEL_ALU ? wb_q.alu_result :
                      wb_q.wb_sel == WB_SEL_MEM ? ld_data :
                      wb_q.wb_sel == WB_SEL_PC4 ? wb_q.pc_plus4 : 32'h0;
   assign wb_valid  = wb_q.valid;
   assign fwd_en    = regWrite;
   assign fwd_rd    = writeReg;
   assign fwd_data  = writeData;
`ifdef WB_INSTRET_EN
   // fresh marks the first cycle a newly loaded instruction is held, so stall repeats
   // and bubbles never count.
   logic        fresh_q, fresh_d;
   logic [63:0] instret_q, instret_d;
   always_comb begin
      fresh_d   = !flush && !stall && in_valid;
      instret_d = instret_q + {63'h0, wb_q.valid & fresh_q};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fresh_q   <= 1'b0;
         instret_q <= 64'h0;
      end else begin
         fresh_q   <= fresh_d;
         instret_q <= instret_d;
      end
   end
   assign instret = instret_q;
`endif
endmodule
